// File: rtl/bubble_mem_pkg.sv
// Shared definitions for the bubble memory responder.
//   DATA_W        - word width in bits
//   DEPTH_DEFAULT - default number of words held
//   ADDR_W        - index width for the default depth
//   state_t       - responder FSM state encoding
package bubble_mem_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEPTH_DEFAULT = 1024;
  localparam int unsigned ADDR_W        = $clog2(DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/bubble_mem_array.sv
// Word storage for the responder: DEPTH x DATA_W words, synchronous
// byte-enabled write and a registered read captured on the access edge.
//   clk   - rising-edge clock
//   en    - perform an access this edge
//   we    - 1 = write enabled bytes, 0 = read word into rdata
//   be    - byte enables for writes
//   addr  - word index
//   wdata - write data
//   rdata - word captured by the most recent read; held otherwise
// Contents and rdata are not reset.
module bubble_mem_array
  import bubble_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bubble_mem_responder.sv
// Single-outstanding memory responder with fixed accept-to-response latency.
// Accepts one load/store in IDLE, waits RD_LAT cycles, then presents a
// response held until the initiator takes it.
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid/ready   - request handshake (ready only in IDLE)
//   req_we            - 1 = store, 0 = load
//   req_addr          - full 32-bit word address, range-checked against DEPTH
//   req_be, req_wdata - store byte enables and data
//   rsp_valid/ready   - response handshake
//   rsp_rdata         - load data; 0 for stores and errors
//   rsp_err           - address was out of range
module bubble_mem_responder
  import bubble_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT lasts RD_LAT-1 cycles; the counter runs from RD_LAT-2 down to 0.
  localparam logic [2:0] LAT_LOAD = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t            state;
  logic [2:0]        cnt;
  logic              load_hit;
  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] mem_rdata;

  // Full-width compare so high address bits can never alias into the array.
  assign in_range  = (req_addr < 32'(DEPTH));
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // The array's read register is the load response register: it only
  // changes on an accepted in-range load, so it is stable through RESP.
  assign rsp_rdata = (rsp_valid && load_hit) ? mem_rdata : '0;

  bubble_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (accept && in_range),
    .we    (req_we),
    .be    (req_be),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_hit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err  <= !in_range;
            load_hit <= in_range && !req_we;
            if (RD_LAT <= 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_hit  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bubble_mem_responder.md
BUBBLE_MEM_RESPONDER -- requirements
Module: bubble_mem_responder

Interface
REQ-001 Parameter RD_LAT, default 2, accept-to-response latency in cycles, legal range 1..7.
REQ-002 Parameter DEPTH, default 1024, number of 32-bit words held.
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store word, 0 = load word.
REQ-009 req_addr  input  32  word address (base register + offset, as computed by the core).
REQ-010 req_be  input  4  byte enables for stores; ignored for loads.
REQ-011 req_wdata  input  32  store data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator takes the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  request address was out of range.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL enter IDLE on reset.
REQ-017 req_ready SHALL be 1 only in IDLE with rst_n high; at most one request is outstanding.
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1 (edge N).
- IDLE to WAIT on accept.
- WAIT counts RD_LAT-1 further cycles, then goes to RESP.
- With RD_LAT=1, IDLE SHALL go directly to RESP.
REQ-019 rsp_valid SHALL be 1 exactly in RESP, first visible in the cycle after edge N+RD_LAT-1, so the response appears RD_LAT cycles after accept.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; that edge SHALL move the FSM to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle the response completes; the next accept is at the earliest one cycle later.
REQ-022 An address is in range when req_addr < DEPTH. Address bits above log2(DEPTH) SHALL be checked, never truncated.
REQ-023 An in-range store SHALL update the enabled bytes at edge N. The response SHALL carry rsp_rdata=0 and rsp_err=0.
REQ-024 An in-range load SHALL capture the word at edge N into a response register. The response SHALL return that captured value.
REQ-025 For an out-of-range request: memory SHALL NOT be accessed or modified, the response SHALL carry rsp_err=1 and rsp_rdata=0, and latency SHALL be unchanged.
REQ-026 A store with req_be=0 SHALL leave memory unchanged and still produce a response.
REQ-027 req_* inputs SHALL be ignored whenever req_ready=0.

Reset
REQ-028 With rst_n low: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
REQ-029 Reset asserted mid-transaction SHALL drop the pending response. A store already performed at its accept edge SHALL remain in memory.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package bubble_mem_pkg SHALL hold DATA_W=32, DEPTH default, ADDR_W=$clog2(DEPTH) and the FSM state type.
REQ-032 Storage SHALL be a sub-module bubble_mem_array: DEPTH x 32 words, synchronous byte-enabled write, and a read captured on the same edge as the request.
REQ-033 The FSM, latency counter, range check and response registers SHALL live in bubble_mem_responder.

Verification
REQ-034 Reset then store then load, RD_LAT=2:
- store addr 10, be=1111, data 32'h0000000C: rsp_valid 2 cycles after accept, rsp_rdata=0, rsp_err=0.
- load addr 10: rsp_rdata=32'h0000000C.
REQ-035 Back-pressure: load with rsp_ready held 0 for 5 cycles. rsp_valid and rsp_rdata SHALL stay stable and req_ready=0 throughout; rsp_ready=1 returns the FSM to IDLE.
REQ-036 Byte enables: store 32'hFFFFFFFF to addr 3, then store 32'h00000000 with be=0101. A load SHALL return 32'hFF00FF00.
REQ-037 Range check:
- load addr 1024 SHALL return rsp_err=1, rsp_rdata=0.
- store addr 32'h0000_0400 SHALL leave addr 0 unchanged.
REQ-038 Reset during WAIT after a store to addr 5 of 32'hA5A5A5A5: no response SHALL appear; after reset, a load of addr 5 SHALL return 32'hA5A5A5A5.
REQ-039 Latency sweep over RD_LAT=1 and RD_LAT=7 with back-to-back requests: accept-to-rsp_valid SHALL equal RD_LAT, with exactly one idle cycle between a completed response and the next accept.
